// File: rtl/fsm_counter_pkg.sv
// fsm_counter_pkg: shared encodings and state classification for the up/down modulus counter.
package fsm_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    typedef enum logic [1:0] {AT_ZERO, MID, AT_MAX} state_e;

    // Equality-only boundary detection, so non-power-of-two moduli work.
    function automatic state_e classify(input int unsigned c, input int unsigned max);
        if (c == 0) return AT_ZERO;
        if (c == max) return AT_MAX;
        return MID;
    endfunction
endpackage

// File: rtl/counter_step.sv
// counter_step: next-count and boundary events for one enabled step of the counter.
module counter_step
    import fsm_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] count,
    input  state_e           state,
    input  logic             up_dn,
    input  logic             mode_sat,
    output logic [WIDTH-1:0] next,
    output logic             wrap_ev,
    output logic             sat_ev
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic up;
    logic hit;

    always_comb begin
        up      = up_dn == DIR_UP;
        hit     = up ? state == AT_MAX : state == AT_ZERO;
        next    = hit ? (mode_sat == MODE_SAT ? count : up ? '0 : MAX_W)
                      : up ? count + 1'b1 : count - 1'b1;
        wrap_ev = hit && mode_sat == MODE_WRAP;
        sat_ev  = hit && mode_sat == MODE_SAT;
    end
endmodule

// File: rtl/fsm_counter_mod.sv
// fsm_counter_mod: WIDTH-bit up/down counter over 0..MAX with clear/load priority,
// wrap or saturate at the boundary, registered wrap pulse and sticky sat flag.
module fsm_counter_mod
    import fsm_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode_sat,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sat
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d, step_next, load_clamp;
    logic             wrap_q, wrap_d, sat_q, sat_d, wrap_ev, sat_ev;
    state_e           state_q, state_d;

    counter_step #(.WIDTH(WIDTH), .MAX(MAX)) u_step (
        .count    (count_q),
        .state    (state_q),
        .up_dn    (up_dn),
        .mode_sat (mode_sat),
        .next     (step_next),
        .wrap_ev  (wrap_ev),
        .sat_ev   (sat_ev)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
            state_q <= AT_ZERO;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
            state_q <= state_d;
        end
    end

    // State tracks the registered count, so it is classified from the count being loaded.
    always_comb begin
        load_clamp = load_val > MAX_W ? MAX_W : load_val;
        count_d    = clear ? '0 : load ? load_clamp : en ? step_next : count_q;
        wrap_d     = !clear && !load && en && wrap_ev;
        sat_d      = !clear && !load && (sat_q || (en && sat_ev));
        state_d    = classify(32'(count_d), MAX);
    end

    always_comb begin
        count = count_q;
        wrap  = wrap_q;
        sat   = sat_q;
    end
endmodule
